// File: rtl/pic_cpu_pkg.sv
// Shared types and constants for the CPU-side 8259 interrupt-acknowledge logic.
// Holds the sequencer state encoding, the 8080 CALL opcode and default pulse timing.
package pic_cpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic [7:0] OPCODE_CALL      = 8'hCD;
  localparam int         DEF_PULSE_CYCLES = 2;
  localparam int         DEF_GAP_CYCLES   = 2;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pic_sync2.sv
// Two-flop synchronizer for a single asynchronous level; 2-cycle latency, no backpressure.
// Both stages reset to 0 so a pending INT is never seen straight out of reset.
module pic_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pic_inta_sequencer.sv
// INTA pulse-train master: 2 pulses (8086) or 3 (8080), captured bytes returned as vec_data.
// Vector valid 2 + n*PULSE + (n-1)*GAP clocks after INT; holds in HOLD until vec_ready.
module pic_inta_sequencer
  import pic_cpu_pkg::*;
#(
  parameter int PULSE_CYCLES = DEF_PULSE_CYCLES,
  parameter int GAP_CYCLES   = DEF_GAP_CYCLES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        mode_8086,
  input  logic        int_in,
  input  logic [7:0]  data_in,
  output logic        inta_n,
  output logic        busy,
  output logic        vec_valid,
  output logic [15:0] vec_data,
  output logic        vec_err,
  input  logic        vec_ready
);

  localparam int            CW         = $clog2(max2(PULSE_CYCLES, GAP_CYCLES) + 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);

  logic int_sync;

  pic_sync2 u_int_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (int_in),
    .q     (int_sync)
  );

  state_t        state_q, state_d;
  logic [CW-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [1:0]    pulse_idx_q, pulse_idx_d;
  logic          mode_q, mode_d;
  logic [7:0]    byte0_q, byte0_d;
  logic [7:0]    byte1_q, byte1_d;
  logic          inta_n_q, inta_n_d;
  logic          vec_valid_q, vec_valid_d;
  logic [15:0]   vec_data_q, vec_data_d;
  logic          vec_err_q, vec_err_d;
  logic          last_pulse;

  always_comb begin
    state_d     = state_q;
    cyc_cnt_d   = cyc_cnt_q;
    pulse_idx_d = pulse_idx_q;
    mode_d      = mode_q;
    byte0_d     = byte0_q;
    byte1_d     = byte1_q;
    vec_valid_d = vec_valid_q;
    vec_data_d  = vec_data_q;
    vec_err_d   = vec_err_q;
    last_pulse  = mode_q ? (pulse_idx_q == 2'd1) : (pulse_idx_q == 2'd2);

    case (state_q)
      IDLE: begin
        if (int_sync && enable) begin
          state_d     = PULSE;
          cyc_cnt_d   = '0;
          pulse_idx_d = 2'd0;
          mode_d      = mode_8086;
          byte0_d     = 8'h00;
          byte1_d     = 8'h00;
        end
      end
      PULSE: begin
        if (cyc_cnt_q == PULSE_LAST) begin
          cyc_cnt_d = '0;
          if (pulse_idx_q == 2'd0) byte0_d = data_in;
          if (pulse_idx_q == 2'd1) byte1_d = data_in;
          if (last_pulse) begin
            // The final byte is taken straight off the bus so the vector is ready on this edge.
            state_d     = HOLD;
            vec_valid_d = 1'b1;
            if (mode_q) begin
              vec_data_d = {8'h00, data_in};
              vec_err_d  = 1'b0;
            end else begin
              vec_data_d = {data_in, byte1_q};
              vec_err_d  = (byte0_q != OPCODE_CALL);
            end
          end else begin
            state_d     = GAP;
            pulse_idx_d = pulse_idx_q + 2'd1;
          end
        end else begin
          cyc_cnt_d = cyc_cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (cyc_cnt_q == GAP_LAST) begin
          state_d   = PULSE;
          cyc_cnt_d = '0;
        end else begin
          cyc_cnt_d = cyc_cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (vec_ready) begin
          state_d     = IDLE;
          vec_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    inta_n_d = (state_d != PULSE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cyc_cnt_q   <= '0;
      pulse_idx_q <= 2'd0;
      mode_q      <= 1'b0;
      byte0_q     <= 8'h00;
      byte1_q     <= 8'h00;
      inta_n_q    <= 1'b1;
      vec_valid_q <= 1'b0;
      vec_data_q  <= 16'h0000;
      vec_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_cnt_q   <= cyc_cnt_d;
      pulse_idx_q <= pulse_idx_d;
      mode_q      <= mode_d;
      byte0_q     <= byte0_d;
      byte1_q     <= byte1_d;
      inta_n_q    <= inta_n_d;
      vec_valid_q <= vec_valid_d;
      vec_data_q  <= vec_data_d;
      vec_err_q   <= vec_err_d;
    end
  end

  assign inta_n    = inta_n_q;
  assign busy      = (state_q != IDLE);
  assign vec_valid = vec_valid_q;
  assign vec_data  = vec_data_q;
  assign vec_err   = vec_err_q;

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Directed bench for pic_inta_sequencer: PIC byte models, expected vectors queued at stimulus time.
// Instance dut uses default timing; dut2 uses PULSE_CYCLES=1, GAP_CYCLES=3 in 8080 mode.
module tb_pic_inta_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable, mode_8086, int_in, vec_ready;
  logic [7:0]  data_in;
  logic        inta_n, busy, vec_valid, vec_err;
  logic [15:0] vec_data;

  logic        int2, ready2;
  logic [7:0]  data2;
  logic        inta2, busy2, valid2, err2;
  logic [15:0] vdata2;

  always #5 clk = ~clk;

  pic_inta_sequencer dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode_8086(mode_8086),
    .int_in(int_in), .data_in(data_in), .inta_n(inta_n), .busy(busy),
    .vec_valid(vec_valid), .vec_data(vec_data), .vec_err(vec_err), .vec_ready(vec_ready)
  );

  pic_inta_sequencer #(.PULSE_CYCLES(1), .GAP_CYCLES(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .enable(1'b1), .mode_8086(1'b0),
    .int_in(int2), .data_in(data2), .inta_n(inta2), .busy(busy2),
    .vec_valid(valid2), .vec_data(vdata2), .vec_err(err2), .vec_ready(ready2)
  );

  // PIC models: byte index advances at the end of every INTA pulse, restarts when idle.
  logic [7:0] pic_bytes  [0:3];
  logic [7:0] pic_bytes2 [0:3];
  logic [1:0] pcnt = 2'd0;
  logic [1:0] pcnt2 = 2'd0;

  always @(posedge inta_n or negedge busy)
    if (!busy) pcnt <= 2'd0; else pcnt <= pcnt + 2'd1;
  always @(posedge inta2 or negedge busy2)
    if (!busy2) pcnt2 <= 2'd0; else pcnt2 <= pcnt2 + 2'd1;

  assign data_in = inta_n ? 8'hEE : pic_bytes[pcnt];
  assign data2   = inta2  ? 8'hEE : pic_bytes2[pcnt2];

  int tests = 0;
  int fails = 0;
  logic [16:0] sb1 [$];
  logic [16:0] sb2 [$];
  logic [31:0] tr_inta, tr_valid, tr_busy;
  logic        stable_ok;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input int sel, input logic [15:0] d, input logic e);
    logic [16:0] exp;
    int          sz;
    sz = (sel == 0) ? sb1.size() : sb2.size();
    check("sb_has_entry", {31'b0, sz != 0}, 32'd1);
    if (sz != 0) begin
      exp = (sel == 0) ? sb1.pop_front() : sb2.pop_front();
      check("vec_data", {16'b0, d}, {16'b0, exp[15:0]});
      check("vec_err", {31'b0, e}, {31'b0, exp[16]});
    end
  endtask

  // Records per-edge traces; bit i holds the value just after edge E+i.
  task automatic do_trace(input int sel, input int n, input int drop_at, input int chg_at);
    logic        got, cv, ce;
    logic [15:0] cd, first;
    tr_inta = '0; tr_valid = '0; tr_busy = '0;
    got = 1'b0; stable_ok = 1'b1; first = '0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (i == drop_at) begin int_in = 1'b0; int2 = 1'b0; end
      if (i == chg_at) begin mode_8086 = ~mode_8086; enable = 1'b0; end
      if (sel == 0) begin
        tr_inta[i] = inta_n; tr_valid[i] = vec_valid; tr_busy[i] = busy;
        cv = vec_valid; cd = vec_data; ce = vec_err;
      end else begin
        tr_inta[i] = inta2; tr_valid[i] = valid2; tr_busy[i] = busy2;
        cv = valid2; cd = vdata2; ce = err2;
      end
      if (cv) begin
        if (!got) begin
          got = 1'b1;
          first = cd;
          pop_check(sel, cd, ce);
        end else if (cd !== first) begin
          stable_ok = 1'b0;
        end
      end
    end
  endtask

  task automatic wait_vec(input int sel, input int bound);
    logic done;
    done = 1'b0;
    for (int i = 0; i < bound && !done; i++) begin
      tick();
      if (sel == 0 && vec_valid) begin done = 1'b1; pop_check(0, vec_data, vec_err); end
      if (sel != 0 && valid2)    begin done = 1'b1; pop_check(1, vdata2, err2); end
    end
    check("vec_seen_in_bound", {31'b0, done}, 32'd1);
  endtask

  initial begin
    enable = 1'b0; mode_8086 = 1'b1; int_in = 1'b0; vec_ready = 1'b0;
    int2 = 1'b0; ready2 = 1'b1;
    for (int i = 0; i < 4; i++) begin pic_bytes[i] = 8'h00; pic_bytes2[i] = 8'h00; end
    #1 rst_n = 1'b0;
    tick(); tick();
    check("rst_inta_n", {31'b0, inta_n}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_vec_valid", {31'b0, vec_valid}, 32'd0);
    check("rst_vec_data", {16'b0, vec_data}, 32'd0);
    check("rst_vec_err", {31'b0, vec_err}, 32'd0);
    rst_n = 1'b1;
    tick();

    // 8086, default timing, int dropped after first pulse
    pic_bytes[0] = 8'hFF; pic_bytes[1] = 8'h0A;
    enable = 1'b1; vec_ready = 1'b1; mode_8086 = 1'b1;
    sb1.push_back({1'b0, 16'h000A});
    int_in = 1'b1;
    do_trace(0, 12, 4, -1);
    check("t8086_inta", tr_inta[11:0], 32'hF33);
    check("t8086_valid", tr_valid[11:0], 32'h100);
    check("t8086_busy", tr_busy[11:0], 32'h1FC);

    // 8080 good CALL; mode and enable flipped mid-sequence must be ignored
    pic_bytes[0] = 8'hCD; pic_bytes[1] = 8'h40; pic_bytes[2] = 8'h12;
    mode_8086 = 1'b0;
    sb1.push_back({1'b0, 16'h1240});
    int_in = 1'b1;
    do_trace(0, 16, 4, 3);
    check("t8080_inta", tr_inta[15:0], 32'hF333);
    check("t8080_valid", tr_valid[15:0], 32'h1000);
    check("t8080_busy", tr_busy[15:0], 32'h1FFC);
    mode_8086 = 1'b0; enable = 1'b1;

    // 8080 with a bad first byte
    pic_bytes[0] = 8'h00;
    sb1.push_back({1'b1, 16'h1240});
    int_in = 1'b1;
    do_trace(0, 16, 4, -1);
    check("t8080err_valid", tr_valid[15:0], 32'h1000);

    // Backpressure with INT held high
    mode_8086 = 1'b1; vec_ready = 1'b0;
    pic_bytes[0] = 8'hFF; pic_bytes[1] = 8'h33;
    sb1.push_back({1'b0, 16'h0033});
    int_in = 1'b1;
    do_trace(0, 20, -1, -1);
    check("bp_inta", tr_inta[19:0], 32'hFFF33);
    check("bp_valid", tr_valid[19:0], 32'hFFF00);
    check("bp_busy", tr_busy[19:0], 32'hFFFFC);
    check("bp_data_stable", {31'b0, stable_ok}, 32'd1);
    vec_ready = 1'b1;
    tick();
    check("bp_rel_valid", {31'b0, vec_valid}, 32'd0);
    check("bp_rel_busy", {31'b0, busy}, 32'd0);
    check("bp_rel_inta", {31'b0, inta_n}, 32'd1);
    tick();
    check("bp_restart_inta", {31'b0, inta_n}, 32'd0);
    check("bp_restart_busy", {31'b0, busy}, 32'd1);
    int_in = 1'b0;
    sb1.push_back({1'b0, 16'h0033});
    wait_vec(0, 20);
    tick();
    check("bp_done_busy", {31'b0, busy}, 32'd0);

    // Enable gating, then INT dropped after first pulse
    enable = 1'b0;
    pic_bytes[1] = 8'h55;
    int_in = 1'b1;
    do_trace(0, 6, -1, -1);
    check("en0_inta", tr_inta[5:0], 32'h3F);
    check("en0_busy", tr_busy[5:0], 32'h0);
    enable = 1'b1;
    tick();
    check("en1_inta", {31'b0, inta_n}, 32'd0);
    tick(); tick();
    check("en1_pulse1_end", {31'b0, inta_n}, 32'd1);
    int_in = 1'b0;
    sb1.push_back({1'b0, 16'h0055});
    wait_vec(0, 20);
    tick();
    check("en1_done_busy", {31'b0, busy}, 32'd0);

    // Asynchronous reset during the second pulse
    pic_bytes[1] = 8'h66;
    int_in = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    check("rst_mid_pulse2", {31'b0, inta_n}, 32'd0);
    int_in = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_inta_n", {31'b0, inta_n}, 32'd1);
    check("arst_vec_valid", {31'b0, vec_valid}, 32'd0);
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_vec_data", {16'b0, vec_data}, 32'd0);
    tick();
    rst_n = 1'b1;
    do_trace(0, 5, -1, -1);
    check("post_rst_inta", tr_inta[4:0], 32'h1F);
    check("post_rst_busy", tr_busy[4:0], 32'h0);

    // Non-default timing: 1-cycle pulses, 3-cycle gaps, 8080 mode
    pic_bytes2[0] = 8'hCD; pic_bytes2[1] = 8'h77; pic_bytes2[2] = 8'h88;
    sb2.push_back({1'b0, 16'h8877});
    int2 = 1'b1;
    do_trace(1, 14, 4, -1);
    check("p1g3_inta", tr_inta[13:0], 32'h3BBB);
    check("p1g3_valid", tr_valid[13:0], 32'h800);
    check("p1g3_busy", tr_busy[13:0], 32'hFFC);

    check("sb1_drained", sb1.size(), 32'd0);
    check("sb2_drained", sb2.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
